// File: rtl/hcode_fifo_pkg.sv
// Shared widths and output-stage state type for the hcode ap_fifo buffer.
package hcode_fifo_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_ADDR_W = 9;
  localparam int PTR_W      = DEF_ADDR_W;
  localparam int CNT_W      = DEF_ADDR_W + 1;

  typedef enum logic {
    EMPTY_OUT = 1'b0,
    VALID_OUT = 1'b1
  } outState_t;

endpackage

// File: rtl/hcode_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no array reset
// so synthesis can map it onto block RAM.
module hcode_sdp_ram
  import hcode_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_q;

  // The read register only moves on i_re, so it doubles as a stall-stable head.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/hcode_ap_fifo_buf.sv
// First-word-fall-through FIFO between ap_fifo write (din/full/write) and
// read (dout/empty_n/read) handshakes, with sticky overflow/underflow flags.
module hcode_ap_fifo_buf
  import hcode_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              ip_clk,
  input  logic              ip_rst_n,
  input  logic [DATA_W-1:0] wr_din,
  input  logic              wr_write,
  output logic              wr_full,
  output logic [DATA_W-1:0] rd_dout,
  output logic              rd_empty_n,
  input  logic              rd_read,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  output logic              udf
);

  localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_PTR  = {{(ADDR_W-1){1'b0}}, 1'b1};

  outState_t         r_state;
  outState_t         w_stateNext;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   w_countNext;
  logic [ADDR_W:0]   w_memCnt;
  logic              r_full;
  logic              r_ovf;
  logic              r_udf;
  logic [DATA_W-1:0] r_byp;
  logic              r_selByp;
  logic [DATA_W-1:0] w_ramQ;
  logic              w_valid;
  logic              w_wrAcc;
  logic              w_rdAcc;
  logic              w_loadRam;
  logic              w_loadByp;

  assign w_valid  = (r_state == VALID_OUT);
  assign w_wrAcc  = wr_write & ~r_full;
  assign w_rdAcc  = rd_read & w_valid;
  assign w_memCnt = r_count - {{ADDR_W{1'b0}}, w_valid};

  hcode_sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (ip_clk),
    .i_we    (w_wrAcc),
    .i_waddr (r_wptr),
    .i_wdata (wr_din),
    .i_re    (w_loadRam),
    .i_raddr (r_rptr),
    .o_rdata (w_ramQ)
  );

  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) r_state <= EMPTY_OUT;
    else           r_state <= w_stateNext;
  end

  // Refill the head from RAM when possible; a word written on the same edge
  // as the last pop is forwarded through the bypass register so no bubble appears.
  always_comb begin
    w_stateNext = r_state;
    w_loadRam   = 1'b0;
    w_loadByp   = 1'b0;
    if (!w_valid || w_rdAcc) begin
      if (w_memCnt != '0) begin
        w_loadRam   = 1'b1;
        w_stateNext = VALID_OUT;
      end else if (w_rdAcc && w_wrAcc) begin
        w_loadByp   = 1'b1;
        w_stateNext = VALID_OUT;
      end else begin
        w_stateNext = EMPTY_OUT;
      end
    end
  end

  always_comb begin
    w_countNext = r_count;
    if (w_wrAcc && !w_rdAcc)      w_countNext = r_count + ONE_CNT;
    else if (!w_wrAcc && w_rdAcc) w_countNext = r_count - ONE_CNT;
  end

  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_byp    <= '0;
      r_selByp <= 1'b1;
    end else begin
      if (w_wrAcc) r_wptr <= r_wptr + ONE_PTR;
      if (w_loadRam || w_loadByp) r_rptr <= r_rptr + ONE_PTR;
      r_count <= w_countNext;
      r_full  <= (w_countNext == FULL_CNT);
      if (wr_write && r_full) r_ovf <= 1'b1;
      if (rd_read && !w_valid) r_udf <= 1'b1;
      if (w_loadByp) begin
        r_byp    <= wr_din;
        r_selByp <= 1'b1;
      end else if (w_loadRam) begin
        r_selByp <= 1'b0;
      end
    end
  end

  // Reset selects the zeroed bypass register so the head reads 0 without resetting the RAM.
  assign rd_dout    = r_selByp ? r_byp : w_ramQ;
  assign rd_empty_n = w_valid;
  assign wr_full    = r_full;
  assign count      = r_count;
  assign ovf        = r_ovf;
  assign udf        = r_udf;

endmodule

// File: tb/tb_hcode_ap_fifo_buf.sv
// Directed self-checking bench for hcode_ap_fifo_buf.
module tb_hcode_ap_fifo_buf;

  logic         ip_clk;
  logic         ip_rst_n;
  logic [127:0] wr_din;
  logic         wr_write;
  logic         wr_full;
  logic [127:0] rd_dout;
  logic         rd_empty_n;
  logic         rd_read;
  logic [9:0]   count;
  logic         ovf;
  logic         udf;

  int vectors = 0;
  int miscompares = 0;

  hcode_ap_fifo_buf dut (
    .ip_clk     (ip_clk),
    .ip_rst_n   (ip_rst_n),
    .wr_din     (wr_din),
    .wr_write   (wr_write),
    .wr_full    (wr_full),
    .rd_dout    (rd_dout),
    .rd_empty_n (rd_empty_n),
    .rd_read    (rd_read),
    .count      (count),
    .ovf        (ovf),
    .udf        (udf)
  );

  initial ip_clk = 1'b0;
  always #2 ip_clk = ~ip_clk;

  function automatic logic [127:0] mkWord(input int i);
    logic [31:0] v;
    v = i;
    return {v, ~v, v ^ 32'hA5A5_A5A5, v};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive inputs, then advance one rising edge and settle 1 ns past it.
  task automatic applyStimulus(input logic wr, input logic [127:0] din, input logic rd);
    wr_write = wr;
    wr_din   = din;
    rd_read  = rd;
    @(posedge ip_clk);
    #1;
  endtask

  task automatic resetFifo();
    wr_write = 1'b0;
    rd_read  = 1'b0;
    wr_din   = '0;
    @(negedge ip_clk);
    ip_rst_n = 1'b0;
    @(negedge ip_clk);
    ip_rst_n = 1'b1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " full"},    128'(wr_full),    128'd0);
    checkOutput({tag, " empty_n"}, 128'(rd_empty_n), 128'd0);
    checkOutput({tag, " dout"},    rd_dout,          128'd0);
    checkOutput({tag, " count"},   128'(count),      128'd0);
    checkOutput({tag, " ovf"},     128'(ovf),        128'd0);
    checkOutput({tag, " udf"},     128'(udf),        128'd0);
  endtask

  // Write n words while reading whenever the head is valid.
  task automatic streamRun(input int n, input int base);
    int wrIdx = 0;
    int rdIdx = 0;
    int cyc = 0;
    logic doRd;
    while (rdIdx < n && cyc < n + 50) begin
      doRd = rd_empty_n;
      if (doRd) checkOutput("stream data", rd_dout, mkWord(base + rdIdx));
      applyStimulus(wrIdx < n, mkWord(base + wrIdx), doRd);
      if (wrIdx < n) wrIdx++;
      if (doRd) rdIdx++;
      checkOutput("stream count<=2", 128'(count <= 10'd2), 128'd1);
      cyc++;
    end
    checkOutput("stream complete", 128'(rdIdx), 128'(n));
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("stream drained", 128'(rd_empty_n), 128'd0);
  endtask

  initial begin
    ip_rst_n = 1'b0;
    wr_write = 1'b0;
    rd_read  = 1'b0;
    wr_din   = '0;
    #5;
    checkResetState("reset");
    @(negedge ip_clk);
    ip_rst_n = 1'b1;

    // Three back-to-back writes, no reads: head valid one edge later and held.
    applyStimulus(1'b1, mkWord(1), 1'b0);
    checkOutput("wr1 empty_n", 128'(rd_empty_n), 128'd0);
    applyStimulus(1'b1, mkWord(2), 1'b0);
    checkOutput("wr2 empty_n", 128'(rd_empty_n), 128'd1);
    checkOutput("wr2 dout", rd_dout, mkWord(1));
    applyStimulus(1'b1, mkWord(3), 1'b0);
    checkOutput("wr3 dout", rd_dout, mkWord(1));
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("wr3 count", 128'(count), 128'd3);
    checkOutput("hold dout", rd_dout, mkWord(1));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("pop1 dout", rd_dout, mkWord(2));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("pop2 dout", rd_dout, mkWord(3));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("pop3 empty_n", 128'(rd_empty_n), 128'd0);
    checkOutput("pop3 count", 128'(count), 128'd0);

    // Sustained streaming across pointer wrap.
    resetFifo();
    streamRun(1000, 100);

    // Fill to capacity, overflow, simultaneous read+write at full, drain.
    resetFifo();
    for (int i = 0; i < 512; i++) applyStimulus(1'b1, mkWord(5000 + i), 1'b0);
    checkOutput("fill full", 128'(wr_full), 128'd1);
    checkOutput("fill count", 128'(count), 128'd512);
    checkOutput("fill ovf", 128'(ovf), 128'd0);
    applyStimulus(1'b1, mkWord(7777), 1'b0);
    checkOutput("ovf flag", 128'(ovf), 128'd1);
    checkOutput("ovf count", 128'(count), 128'd512);
    checkOutput("full head", rd_dout, mkWord(5000));
    applyStimulus(1'b1, mkWord(8888), 1'b1);
    checkOutput("wr+rd full count", 128'(count), 128'd511);
    checkOutput("wr+rd full flag", 128'(wr_full), 128'd0);
    checkOutput("wr+rd full ovf", 128'(ovf), 128'd1);
    applyStimulus(1'b1, mkWord(9999), 1'b0);
    checkOutput("refill count", 128'(count), 128'd512);
    checkOutput("refill full", 128'(wr_full), 128'd1);
    for (int i = 0; i < 512; i++) begin
      checkOutput("drain data", rd_dout, (i < 511) ? mkWord(5001 + i) : mkWord(9999));
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("drain empty_n", 128'(rd_empty_n), 128'd0);
    checkOutput("drain count", 128'(count), 128'd0);

    // Read while empty.
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("udf flag", 128'(udf), 128'd1);
    checkOutput("udf count", 128'(count), 128'd0);
    checkOutput("udf empty_n", 128'(rd_empty_n), 128'd0);
    applyStimulus(1'b0, '0, 1'b0);

    // Single word held, write and pop together: new word is head immediately.
    resetFifo();
    applyStimulus(1'b1, mkWord(40), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("single head", rd_dout, mkWord(40));
    applyStimulus(1'b1, mkWord(41), 1'b1);
    checkOutput("bypass empty_n", 128'(rd_empty_n), 128'd1);
    checkOutput("bypass dout", rd_dout, mkWord(41));
    checkOutput("bypass count", 128'(count), 128'd1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("bypass drained", 128'(rd_empty_n), 128'd0);

    // Wrap pointers, hold 5 words with flags set, then assert reset asynchronously.
    resetFifo();
    streamRun(600, 20000);
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, mkWord(300 + i), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("pre-reset count", 128'(count), 128'd5);
    checkOutput("pre-reset udf", 128'(udf), 128'd1);
    ip_rst_n = 1'b0;
    #1;
    checkResetState("async reset");
    @(negedge ip_clk);
    ip_rst_n = 1'b1;
    applyStimulus(1'b1, mkWord(55), 1'b0);
    checkOutput("post-reset k empty_n", 128'(rd_empty_n), 128'd0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("post-reset k+1 empty_n", 128'(rd_empty_n), 128'd1);
    checkOutput("post-reset k+1 dout", rd_dout, mkWord(55));
    checkOutput("post-reset count", 128'(count), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hcode_ap_fifo_buf.md
# hcode_ap_fifo_buf

Shell-side 128-bit first-word-fall-through FIFO terminating the ap_fifo handshake from both ends: the write port takes the `din/full/write` triple an IP drives out of its subshell, and the read port presents the `dout/empty_n/read` triple a subshell consumes. It sits between a Xillybus stream endpoint and a subshell (or between two subshells) in the 250 MHz user clock domain. It buffers, applies backpressure and flags protocol misuse, but never reorders or alters data.

## Interface
- `DATA_W`, 128, data width of both ports
- `ADDR_W`, 9, log2 of depth; `DEPTH` = 2**ADDR_W = 512 words
- `ip_clk`  in  1  single clock; all logic on its rising edge
- `ip_rst_n`  in  1  reset, asynchronous, active-low
- `wr_din`  in  DATA_W  write data
- `wr_write`  in  1  write strobe; accepted only when `wr_full`=0
- `wr_full`  out  1  high: no space; active-high, as subshells expect
- `rd_dout`  out  DATA_W  head word; valid whenever `rd_empty_n`=1
- `rd_empty_n`  out  1  high: head word present
- `rd_read`  in  1  pop strobe; effective only when `rd_empty_n`=1
- `count`  out  ADDR_W+1  words held, including the output stage
- `ovf`  out  1  sticky: write attempted while full
- `udf`  out  1  sticky: read attempted while empty

## Operation
- Reset values: `wr_full`=0, `rd_empty_n`=0, `rd_dout`=0, `count`=0, `ovf`=0, `udf`=0. Both pointers are 0.
- Reset asserted mid-operation: all contents are discarded immediately. Outputs take their reset values asynchronously.
- Accepted write: `wr_write`=1 and `wr_full`=0 at the edge. The word is stored at `wptr`, and `wptr` wraps modulo DEPTH.
- Refused write: `wr_write`=1 and `wr_full`=1. Data is dropped, `ovf` is set, and no other state changes.
- Accepted read: `rd_read`=1 and `rd_empty_n`=1. The head word is consumed and the next word, if any, is presented.
- Refused read: `rd_read`=1 and `rd_empty_n`=0. `udf` is set and nothing else changes.
- `count`:
  - +1 on an accepted write alone.
  - −1 on an accepted read alone.
  - Unchanged when both happen on the same edge.
  - Range is 0..DEPTH.
- `wr_full` is registered and equals (`count`==DEPTH).
- Simultaneous write and read while full: the write is refused because `wr_full` was 1. `ovf` is set, the read completes, and `wr_full` drops.
- Simultaneous write and read with one word held: both are accepted, and the new word becomes the head with no bubble.
- Output stage is a prefetch register fed from the RAM's registered read port. It has two states:
  - EMPTY_OUT: no valid head; `rd_empty_n`=0.
  - VALID_OUT: `rd_empty_n`=1.
  - Transitions: EMPTY_OUT→VALID_OUT when a word arrives from the RAM. VALID_OUT→EMPTY_OUT on a pop with no successor word available.
- `rd_dout` holds its value while `rd_read`=0; there is no drift while stalled.
- Ordering is strict FIFO. Data bits pass through unchanged.

## Timing
- Write latency: a write accepted at edge k into an empty FIFO gives `rd_empty_n`=1 and `rd_dout`=that word after edge k+1.
- Streaming throughput: one word per clock in each direction, sustained, with no bubbles once the head is valid.
- Pop latency: a pop at edge j presents the successor word after edge j, when the successor is already in RAM.
- `count`, `wr_full`, `ovf`, `udf` all update at the same edge as the causing event.
- Full release: the first read after full lets `wr_full` fall after that edge. A write in the next cycle is then accepted.

## Structure
- Package `hcode_fifo_pkg` holds `DATA_W` and `ADDR_W` defaults, the output-state enum (EMPTY_OUT, VALID_OUT), and the pointer and count width constants.
- Sub-module `hcode_sdp_ram`: simple dual-port RAM with one write port and one registered read port, DEPTH × DATA_W, no reset on the array, inferred as BRAM.
- The top holds the pointers, count, prefetch/output control and the sticky flags.

## Test plan
- Reset, then write 0x…01, 0x…02, 0x…03 on back-to-back edges with `rd_read`=0. Expect `rd_empty_n`=1 one edge after the first write, `rd_dout`=0x…01 held steady, and `count`=3.
- Write and read continuously, one word per clock, 1000 incrementing words. Expect the output sequence to equal the input sequence with no gaps, and `count` to stay ≤2.
- Write 512 words. Expect `wr_full`=1 and `count`=512. A 513th write is dropped and sets `ovf`=1. A subsequent read drains 512 words in order with no extra word.
- While full, assert `wr_write`=1 and `rd_read`=1 on the same edge. Expect the write refused, `ovf`=1, `count`=511, `wr_full`=0, and the next write accepted.
- Pulse `rd_read` while empty. Expect `udf`=1, `count`=0, and `rd_empty_n`=0.
- With 600 words cycled through (pointer wrap) and `count`=5, assert `ip_rst_n`=0 asynchronously. Expect `count`=0, `rd_empty_n`=0, `rd_dout`=0 and flags 0 immediately. After release, the first new word appears after edge k+1.
